// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words from a gated serial
// stream and hands each finished word over through a held valid/ready register.
module sipo_deserializer #(
    parameter int  WIDTH     = 4,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_en,
    input  logic             clr,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] word;
    logic             complete;
    logic             accept;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
        if (MSB_FIRST)
            return {s[WIDTH-2:0], b};
        else
            return {b, s[WIDTH-1:1]};
    endfunction

    // The completing word includes the bit sampled on this very edge.
    assign word     = shift_in(sreg, ser_in);
    assign complete = ser_en && !clr && (bit_cnt == CNT_W'(WIDTH - 1));
    assign accept   = par_valid && par_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= '0;
            bit_cnt   <= '0;
            par_out   <= '0;
            par_valid <= 1'b0;
            overrun   <= 1'b0;
            state     <= EMPTY;
        end else begin
            if (clr) begin
                sreg    <= '0;
                bit_cnt <= '0;
                overrun <= 1'b0;
            end else if (ser_en) begin
                sreg    <= word;
                bit_cnt <= complete ? '0 : bit_cnt + CNT_W'(1);
            end

            // Output register: clr never blocks an accept, and complete already excludes clr.
            case (state)
                EMPTY: begin
                    if (complete) begin
                        par_out   <= word;
                        par_valid <= 1'b1;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    if (complete && accept) begin
                        par_out <= word;
                    end else if (complete) begin
                        overrun <= 1'b1;
                    end else if (accept) begin
                        par_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                default: begin
                    par_valid <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: an MSB-first and an LSB-first instance
// share one stimulus stream; expected words are queued as they are sent.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst, ser_in, ser_en, clr, par_ready;
    logic [3:0] par_out1, par_out0;
    logic       par_valid1, par_valid0, overrun1, overrun0;
    logic [1:0] bit_cnt1, bit_cnt0;

    int checks = 0;
    int errors = 0;
    logic [3:0] q1[$];
    logic [3:0] q0[$];

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en), .clr(clr),
        .par_out(par_out1), .par_valid(par_valid1), .par_ready(par_ready),
        .overrun(overrun1), .bit_cnt(bit_cnt1)
    );

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en), .clr(clr),
        .par_out(par_out0), .par_valid(par_valid0), .par_ready(par_ready),
        .overrun(overrun0), .bit_cnt(bit_cnt0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_en = 1'b1;
        ser_in = b;
        tick();
        ser_en = 1'b0;
        ser_in = 1'b0;
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic check_present(input string tag);
        logic [3:0] e1, e0;
        if (q1.size() == 0 || q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: observed empty scoreboard expected queued word", tag);
        end else begin
            e1 = q1.pop_front();
            e0 = q0.pop_front();
            chk({tag, " valid msb"}, par_valid1, 1'b1);
            chk({tag, " valid lsb"}, par_valid0, 1'b1);
            chk({tag, " word msb"}, par_out1, e1);
            chk({tag, " word lsb"}, par_out0, e0);
        end
    endtask

    // Bits go out first-to-last as w[3], w[2], w[1], w[0].
    task automatic send_word(input logic [3:0] w, input int gap_n, input bit expect_new, input string tag);
        for (int i = 3; i >= 0; i--) begin
            send_bit(w[i]);
            if (i > 0) repeat (gap_n) tick();
        end
        if (expect_new) begin
            q1.push_back(w);
            q0.push_back(rev4(w));
            check_present(tag);
        end
    endtask

    task automatic accept_word(input string tag);
        par_ready = 1'b1;
        tick();
        par_ready = 1'b0;
        chk({tag, " drained"}, {par_valid1, par_valid0}, 2'b00);
    endtask

    initial begin
        rst = 1'b1; ser_in = 1'b0; ser_en = 1'b0; clr = 1'b0; par_ready = 1'b0;
        tick();
        tick();
        chk("reset par_out", {par_out1, par_out0}, 8'h00);
        chk("reset valid", {par_valid1, par_valid0}, 2'b00);
        chk("reset overrun", {overrun1, overrun0}, 2'b00);
        chk("reset bit_cnt", {bit_cnt1, bit_cnt0}, 4'h0);
        rst = 1'b0;

        // 1) back-to-back bits 1,0,0,1
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("t1 bit_cnt 3", bit_cnt1, 2'd3);
        send_bit(1'b1);
        q1.push_back(4'b1001);
        q0.push_back(4'b1001);
        check_present("t1");
        chk("t1 bit_cnt wrap", bit_cnt1, 2'd0);
        accept_word("t1");

        // 2) bits 1,1,0,0 with two-cycle gaps
        send_bit(1'b1);
        tick();
        tick();
        chk("t2 bit_cnt hold", {bit_cnt1, bit_cnt0}, 4'b0101);
        chk("t2 no early valid", par_valid1, 1'b0);
        send_bit(1'b1);
        repeat (2) tick();
        send_bit(1'b0);
        repeat (2) tick();
        send_bit(1'b0);
        q1.push_back(4'b1100);
        q0.push_back(4'b0011);
        check_present("t2");
        accept_word("t2");

        // 3) consumer stalls across two words, then clr with a same-edge accept
        send_word(4'b1010, 0, 1'b1, "t3 first");
        chk("t3 no overrun yet", overrun1, 1'b0);
        send_word(4'b0110, 0, 1'b0, "t3 second");
        chk("t3 held msb", par_out1, 4'b1010);
        chk("t3 held lsb", par_out0, 4'b0101);
        chk("t3 overrun", {overrun1, overrun0}, 2'b11);
        tick();
        chk("t3 overrun sticky", overrun1, 1'b1);
        clr = 1'b1;
        par_ready = 1'b1;
        tick();
        clr = 1'b0;
        par_ready = 1'b0;
        chk("t3 clr overrun", {overrun1, overrun0}, 2'b00);
        chk("t3 clr accept", {par_valid1, par_valid0}, 2'b00);

        // 4) continuous stream with an always-ready consumer
        par_ready = 1'b1;
        send_word(4'b1100, 0, 1'b1, "t4 w1");
        send_bit(1'b0);
        chk("t4 accepted", par_valid1, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        q1.push_back(4'b0101);
        q0.push_back(4'b1010);
        check_present("t4 w2");
        send_word(4'b1111, 0, 1'b1, "t4 w3");
        chk("t4 overrun", {overrun1, overrun0}, 2'b00);

        // Completion and accept on the same edge replaces the word without overrun
        par_ready = 1'b0;
        tick();
        chk("t4b held valid", par_valid1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        par_ready = 1'b1;
        send_bit(1'b1);
        par_ready = 1'b0;
        q1.push_back(4'b0011);
        q0.push_back(4'b1100);
        check_present("t4b replace");
        chk("t4b overrun", {overrun1, overrun0}, 2'b00);
        accept_word("t4b");

        // 5) reset mid-frame, with ser_en active on the reset edge
        send_bit(1'b1);
        send_bit(1'b1);
        par_ready = 1'b1;
        rst = 1'b1;
        ser_en = 1'b1;
        ser_in = 1'b1;
        tick();
        rst = 1'b0;
        ser_en = 1'b0;
        ser_in = 1'b0;
        par_ready = 1'b0;
        chk("t5 rst par_out", {par_out1, par_out0}, 8'h00);
        chk("t5 rst valid", {par_valid1, par_valid0}, 2'b00);
        chk("t5 rst bit_cnt", {bit_cnt1, bit_cnt0}, 4'h0);
        chk("t5 rst overrun", {overrun1, overrun0}, 2'b00);
        send_word(4'b0110, 0, 1'b1, "t5");
        accept_word("t5");

        // 6) clr after three bits discards them and the bit sampled with it
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        clr = 1'b1;
        ser_en = 1'b1;
        ser_in = 1'b1;
        tick();
        clr = 1'b0;
        ser_en = 1'b0;
        ser_in = 1'b0;
        chk("t6 clr bit_cnt", {bit_cnt1, bit_cnt0}, 4'h0);
        chk("t6 clr no valid", par_valid1, 1'b0);
        send_word(4'b1000, 0, 1'b1, "t6");
        chk("t6 scoreboard empty", q1.size() + q0.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
